// File: rtl/alien_hit_detector.sv
// alien_hit_detector
//
// Resolves a player bullet against the alien formation. A check strobe
// that arrives while a bullet is in flight latches the bullet position.
// The block then evaluates one alien per cycle. It starts with the bottom
// row and moves left to right within each row. The first alive alien whose
// hitbox overlaps the bullet is reported as a kill over a valid/ready
// handshake. At most one kill is reported per scan.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   check_strobe          one-cycle request to run a scan
//   bullet_valid          a player bullet is in flight
//   bullet_x, bullet_y    bullet top-left position (10 bit)
//   alive_matrix          alien alive flags, sampled live while scanning
//   alien_positions_x/y   alien top-left positions (16 bit each)
//   kill_valid/kill_ready kill report handshake
//   kill_row, kill_col    coordinates of the hit alien
//   score_add             points for the hit: 10*(NUM_ROWS-kill_row)
//   busy                  high while scanning or reporting
//   scan_done             one-cycle pulse on return to idle
//   scan_hit              qualifies scan_done: the scan ended in an accepted kill
module alien_hit_detector #(
  parameter int NUM_ROWS = 3,
  parameter int NUM_COLS = 5,
  parameter int ALIEN_W  = 16,
  parameter int ALIEN_H  = 16,
  parameter int BULLET_W = 2,
  parameter int BULLET_H = 8,
  localparam int ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int COL_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             check_strobe,
  input  logic                             bullet_valid,
  input  logic [9:0]                       bullet_x,
  input  logic [9:0]                       bullet_y,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0] alive_matrix,
  input  logic [15:0]                      alien_positions_x [NUM_ROWS-1:0][NUM_COLS-1:0],
  input  logic [15:0]                      alien_positions_y [NUM_ROWS-1:0][NUM_COLS-1:0],
  output logic                             kill_valid,
  input  logic                             kill_ready,
  output logic [ROW_W-1:0]                 kill_row,
  output logic [COL_W-1:0]                 kill_col,
  output logic [7:0]                       score_add,
  output logic                             busy,
  output logic                             scan_done,
  output logic                             scan_hit
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT
  } state_t;

  state_t           state;
  logic [9:0]       bx_q;
  logic [9:0]       by_q;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;

  // All comparisons are done in 17 bits. This means that an alien near
  // the top of the 16-bit range cannot wrap its far edge back to zero.
  logic [16:0] ax, ay, bx, by;
  logic        overlap;
  logic        hit;
  logic        last_col;
  logic        last_idx;

  // NOTE: each signal gets a value on every path through always_comb.
  // This prevents the tool from inferring a latch to hold the old value.
  always_comb begin
    ax       = {1'b0, alien_positions_x[row][col]};
    ay       = {1'b0, alien_positions_y[row][col]};
    bx       = {7'd0, bx_q};
    by       = {7'd0, by_q};
    overlap  = (bx <= ax + 17'(ALIEN_W - 1))  && (ax <= bx + 17'(BULLET_W - 1)) &&
               (by <= ay + 17'(ALIEN_H - 1))  && (ay <= by + 17'(BULLET_H - 1));
    hit      = alive_matrix[row][col] && overlap;
    last_col = (col == COL_W'(NUM_COLS - 1));
    last_idx = last_col && (row == '0);
  end

  // NOTE: all state updates use non-blocking assignment. Every register
  // therefore sees the pre-edge values of its neighbours, in any order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bx_q       <= '0;
      by_q       <= '0;
      row        <= '0;
      col        <= '0;
      kill_valid <= 1'b0;
      kill_row   <= '0;
      kill_col   <= '0;
      score_add  <= '0;
      busy       <= 1'b0;
      scan_done  <= 1'b0;
      scan_hit   <= 1'b0;
    end else begin
      // scan_done/scan_hit are single-cycle pulses. They are re-raised
      // only on the transition back to IDLE.
      scan_done <= 1'b0;
      scan_hit  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (check_strobe && bullet_valid) begin
            bx_q  <= bullet_x;
            by_q  <= bullet_y;
            row   <= ROW_W'(NUM_ROWS - 1);
            col   <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end

        SCAN: begin
          if (hit) begin
            kill_row   <= row;
            kill_col   <= col;
            score_add  <= 8'(10 * (NUM_ROWS - int'(row)));
            kill_valid <= 1'b1;
            state      <= REPORT;
          end else if (last_idx) begin
            busy      <= 1'b0;
            scan_done <= 1'b1;
            state     <= IDLE;
          end else if (last_col) begin
            col <= '0;
            row <= row - 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end

        REPORT: begin
          // The kill fields are held untouched until the consumer accepts.
          if (kill_ready) begin
            kill_valid <= 1'b0;
            busy       <= 1'b0;
            scan_done  <= 1'b1;
            scan_hit   <= 1'b1;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alien_hit_detector.sv
// Self-checking bench for alien_hit_detector. The stimulus pushes the
// expected kill reports and scan completions into queues. A monitor pops
// an entry and compares it whenever the DUT presents a kill handshake or
// a scan_done pulse. The formation is placed with alien (r,c) at
// x=100+64c, y=50+32r.
module tb_alien_hit_detector;

  localparam int NR = 3;
  localparam int NC = 5;

  logic              clk;
  logic              rst;
  logic              check_strobe;
  logic              bullet_valid;
  logic [9:0]        bullet_x;
  logic [9:0]        bullet_y;
  logic [NR-1:0][NC-1:0] alive_matrix;
  logic [15:0]       alien_positions_x [NR-1:0][NC-1:0];
  logic [15:0]       alien_positions_y [NR-1:0][NC-1:0];
  logic              kill_valid;
  logic              kill_ready;
  logic [1:0]        kill_row;
  logic [2:0]        kill_col;
  logic [7:0]        score_add;
  logic              busy;
  logic              scan_done;
  logic              scan_hit;

  alien_hit_detector dut (
    .clk               (clk),
    .rst               (rst),
    .check_strobe      (check_strobe),
    .bullet_valid      (bullet_valid),
    .bullet_x          (bullet_x),
    .bullet_y          (bullet_y),
    .alive_matrix      (alive_matrix),
    .alien_positions_x (alien_positions_x),
    .alien_positions_y (alien_positions_y),
    .kill_valid        (kill_valid),
    .kill_ready        (kill_ready),
    .kill_row          (kill_row),
    .kill_col          (kill_col),
    .score_add         (score_add),
    .busy              (busy),
    .scan_done         (scan_done),
    .scan_hit          (scan_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  typedef struct {
    int row;
    int col;
    int score;
    int vcyc;   // first cycle kill_valid must be high
  } kill_t;

  typedef struct {
    int hit;
    int dcyc;   // cycle scan_done must pulse
  } done_t;

  kill_t kill_q[$];
  done_t done_q[$];

  // Monitor: samples on the falling edge, away from the active edge.
  logic prev_kv = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_kv = 1'b0;
    end else begin
      if (kill_valid) begin
        check("kill_expected", int'(kill_q.size() != 0), 1);
        if (kill_q.size() != 0) begin
          check("kill_row", int'(kill_row), kill_q[0].row);
          check("kill_col", int'(kill_col), kill_q[0].col);
          check("score_add", int'(score_add), kill_q[0].score);
          if (!prev_kv) check("kill_valid_cycle", cyc, kill_q[0].vcyc);
          if (kill_ready) void'(kill_q.pop_front());
        end
      end
      prev_kv = kill_valid;
      if (scan_done) begin
        check("done_expected", int'(done_q.size() != 0), 1);
        check("busy_at_done", int'(busy), 0);
        if (done_q.size() != 0) begin
          check("scan_hit", int'(scan_hit), done_q[0].hit);
          check("scan_done_cycle", cyc, done_q[0].dcyc);
          void'(done_q.pop_front());
        end
      end
    end
  end

  // Advance to the drive point of cycle c, 1 time unit after the posedge
  // that opens it.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_scan(input int x, input int y, output int c0);
    goto(cyc + 1);
    bullet_x     = 10'(x);
    bullet_y     = 10'(y);
    bullet_valid = 1'b1;
    check_strobe = 1'b1;
    c0 = cyc;
    goto(cyc + 1);
    check_strobe = 1'b0;
  endtask

  task automatic push_kill(input int r, input int c, input int s, input int vc);
    kill_t k;
    k.row = r; k.col = c; k.score = s; k.vcyc = vc;
    kill_q.push_back(k);
  endtask

  task automatic push_done(input int h, input int dc);
    done_t d;
    d.hit = h; d.dcyc = dc;
    done_q.push_back(d);
  endtask

  // The run must always end: a stuck bench reports and stops.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    rst          = 1'b1;
    check_strobe = 1'b0;
    bullet_valid = 1'b0;
    bullet_x     = '0;
    bullet_y     = '0;
    kill_ready   = 1'b1;
    alive_matrix = '1;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) begin
        alien_positions_x[r][c] = 16'(100 + 64 * c);
        alien_positions_y[r][c] = 16'(50 + 32 * r);
      end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_kill_valid", int'(kill_valid), 0);
    check("rst_kill_row", int'(kill_row), 0);
    check("rst_kill_col", int'(kill_col), 0);
    check("rst_score_add", int'(score_add), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_scan_done", int'(scan_done), 0);
    check("rst_scan_hit", int'(scan_hit), 0);

    // Bottom-left hit, ready already high: accepted in the first cycle
    kill_ready = 1'b1;
    start_scan(105, 120, c0);
    push_kill(2, 0, 10, c0 + 2);
    push_done(1, c0 + 3);
    goto(c0 + 1);
    @(negedge clk);
    check("busy_cycle1", int'(busy), 1);
    goto(c0 + 4);

    // Top-row hit at index 13 with ready low for three cycles
    kill_ready = 1'b0;
    start_scan(295, 55, c0);
    push_kill(0, 3, 30, c0 + 15);
    push_done(1, c0 + 19);
    goto(c0 + 17);
    @(negedge clk);
    check("bp_kill_valid_held", int'(kill_valid), 1);
    goto(c0 + 18);
    kill_ready = 1'b1;
    goto(c0 + 20);

    // Full miss
    start_scan(20, 400, c0);
    push_done(0, c0 + 16);
    goto(c0 + 17);

    // Bullet just right of alien (2,0): x=116 misses
    start_scan(116, 120, c0);
    push_done(0, c0 + 16);
    goto(c0 + 17);

    // Bullet's right edge touches alien (2,0) left edge: x=99 hits
    start_scan(99, 120, c0);
    push_kill(2, 0, 10, c0 + 2);
    push_done(1, c0 + 3);
    goto(c0 + 4);

    // Dead bottom alien: the bullet overlaps (2,0) and a lowered (1,0),
    // so the kill goes to row 1 at index 5
    alive_matrix[2][0]      = 1'b0;
    alien_positions_y[1][0] = 16'd110;
    start_scan(105, 115, c0);
    push_kill(1, 0, 20, c0 + 7);
    push_done(1, c0 + 8);
    goto(c0 + 9);
    alive_matrix[2][0]      = 1'b1;
    alien_positions_y[1][0] = 16'd82;

    // A strobe plus a moved bullet during SCAN are ignored, so the scan
    // still misses. A fresh strobe in the scan_done cycle is accepted.
    start_scan(20, 400, c0);
    push_done(0, c0 + 16);
    goto(c0 + 5);
    bullet_x     = 10'd105;
    bullet_y     = 10'd120;
    check_strobe = 1'b1;
    goto(c0 + 6);
    check_strobe = 1'b0;
    bullet_x     = 10'd20;
    bullet_y     = 10'd400;
    goto(c0 + 16);
    bullet_x     = 10'd105;
    bullet_y     = 10'd120;
    check_strobe = 1'b1;
    push_kill(2, 0, 10, c0 + 18);
    push_done(1, c0 + 19);
    goto(c0 + 17);
    check_strobe = 1'b0;
    goto(c0 + 20);

    // A strobe without a bullet in flight does nothing
    goto(cyc + 1);
    bullet_valid = 1'b0;
    check_strobe = 1'b1;
    c0 = cyc;
    goto(c0 + 1);
    check_strobe = 1'b0;
    @(negedge clk);
    check("novalid_busy_c1", int'(busy), 0);
    goto(c0 + 2);
    @(negedge clk);
    check("novalid_busy_c2", int'(busy), 0);

    // Reset mid-SCAN aborts at once and emits no scan_done
    start_scan(20, 400, c0);
    goto(c0 + 3);
    @(negedge clk);
    check("pre_rst_busy", int'(busy), 1);
    goto(c0 + 4);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_kill_valid", int'(kill_valid), 0);
    check("mid_rst_scan_done", int'(scan_done), 0);
    check("mid_rst_score_add", int'(score_add), 0);
    goto(c0 + 5);
    rst = 1'b0;
    goto(c0 + 25);
    @(negedge clk);
    check("post_rst_busy", int'(busy), 0);

    // Every expected report was consumed
    check("kill_queue_drained", kill_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
